btn_debounce_multi: RTL and testbench

//  Parametrised N-channel push-button conditioner: per-channel 2-FF synchroniser, debounce by

---
 rtl/btn_pkg.sv | 25 ++
 rtl/btn_debounce_ch.sv | 93 +++++++++
 rtl/btn_debounce_multi.sv | 50 +++++
 tb/tb_btn_debounce_multi.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants, counter-width helper and per-channel event record for the
// push-button conditioner.
package btn_pkg;

    // Defaults assume a 100 MHz clock: 2 ms debounce, 1 s long press, 200 ms repeat.
    localparam int DEF_STABLE_CYCLES = 200_000;
    localparam int DEF_LONG_CYCLES   = 100_000_000;
    localparam int DEF_REPEAT_CYCLES = 20_000_000;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic level;
        logic press;
        logic unpress;
        logic long_press;
        logic auto_rpt;
    } btn_event_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability-count debounce, hold timer
// with long-press strobe and optional auto-repeat. All outputs registered.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b,
    output btn_event_t ev
);

    localparam int DW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES + 1);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] D_LAST = DW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

    logic          s0_reg, s1_reg;
    logic          level_reg, press_reg, release_reg, long_reg, repeat_reg;
    logic [DW-1:0] dcnt_reg;
    logic [HW-1:0] hcnt_reg;
    logic [RW-1:0] rcnt_reg;
    logic          flip;

    assign flip = (s1_reg != level_reg) && (dcnt_reg == D_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_reg      <= 1'b0;
            s1_reg      <= 1'b0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
            dcnt_reg    <= '0;
            hcnt_reg    <= '0;
            rcnt_reg    <= '0;
        end else begin
            s0_reg      <= b;
            s1_reg      <= s0_reg;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;

            if (s1_reg == level_reg) begin
                dcnt_reg <= '0;
            end else if (flip) begin
                dcnt_reg    <= '0;
                level_reg   <= s1_reg;
                press_reg   <= s1_reg;
                release_reg <= ~s1_reg;
            end else begin
                dcnt_reg <= dcnt_reg + DW'(1);
            end

            // A release on this edge clears the hold state and masks long/repeat.
            if (!level_reg || flip) begin
                hcnt_reg <= '0;
                rcnt_reg <= '0;
            end else begin
                if (hcnt_reg != H_MAX)
                    hcnt_reg <= hcnt_reg + HW'(1);
                if (hcnt_reg == H_LAST)
                    long_reg <= 1'b1;
                if ((REPEAT_EN != 0) && (hcnt_reg == H_MAX)) begin
                    if (rcnt_reg == R_LAST) begin
                        rcnt_reg   <= '0;
                        repeat_reg <= 1'b1;
                    end else begin
                        rcnt_reg <= rcnt_reg + RW'(1);
                    end
                end
            end
        end
    end

    assign ev = '{level:      level_reg,
                  press:      press_reg,
                  unpress:    release_reg,
                  long_press: long_reg,
                  auto_rpt:   repeat_reg};

endmodule

// File: rtl/btn_debounce_multi.sv
// N independent push-button channels with optional pin inversion; each channel
// yields a debounced level plus press/release/long/repeat strobes.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int CH            = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] btn,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press_p,
    output logic [CH-1:0] release_p,
    output logic [CH-1:0] long_p,
    output logic [CH-1:0] repeat_p
);

    btn_event_t ev [CH];

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic b;
            assign b = (ACTIVE_LOW != 0) ? ~btn[gi] : btn[gi];

            btn_debounce_ch #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .LONG_CYCLES  (LONG_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES),
                .REPEAT_EN    (REPEAT_EN)
            ) u_ch (
                .clk(clk),
                .rst(rst),
                .b  (b),
                .ev (ev[gi])
            );

            assign level[gi]     = ev[gi].level;
            assign press_p[gi]   = ev[gi].press;
            assign release_p[gi] = ev[gi].unpress;
            assign long_p[gi]    = ev[gi].long_press;
            assign repeat_p[gi]  = ev[gi].auto_rpt;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: an active-high and an active-low instance run side
// by side against an event-level reference model, plus directed timing checks.
module tb_btn_debounce_multi;

    localparam int CH     = 2;
    localparam int STABLE = 4;
    localparam int LONG   = 16;
    localparam int RPT    = 8;
    localparam int NM     = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] btn_a = '0;
    logic [CH-1:0] btn_b = '1;
    logic [CH-1:0] level_a, press_p_a, release_p_a, long_p_a, repeat_p_a;
    logic [CH-1:0] level_b, press_p_b, release_p_b, long_p_b, repeat_p_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .CH(CH), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(RPT), .REPEAT_EN(1), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .btn(btn_a),
        .level(level_a), .press_p(press_p_a), .release_p(release_p_a),
        .long_p(long_p_a), .repeat_p(repeat_p_a)
    );

    btn_debounce_multi #(
        .CH(CH), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(RPT), .REPEAT_EN(1), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn(btn_b),
        .level(level_b), .press_p(press_p_b), .release_p(release_p_b),
        .long_p(long_p_b), .repeat_p(repeat_p_b)
    );

    // Reference model: channels 0-1 belong to dut_a, 2-3 to dut_b.
    bit hist1_m [NM];   // pressed value sampled one edge ago
    bit hist2_m [NM];   // pressed value sampled two edges ago (what the filter sees)
    bit lvl_m   [NM];
    int run_m   [NM];   // consecutive edges the filtered input disagreed with level
    int held_m  [NM];   // edges spent pressed since the press edge
    bit pr_m [NM], rl_m [NM], lg_m [NM], rp_m [NM];

    function automatic void model_reset();
        for (int c = 0; c < NM; c++) begin
            hist1_m[c] = 0; hist2_m[c] = 0; lvl_m[c] = 0;
            run_m[c] = 0; held_m[c] = 0;
            pr_m[c] = 0; rl_m[c] = 0; lg_m[c] = 0; rp_m[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < NM; c++) begin
            bit pressed, seen, was;
            pressed = (c < CH) ? btn_a[c] : ~btn_b[c - CH];
            seen    = hist2_m[c];
            hist2_m[c] = hist1_m[c];
            hist1_m[c] = pressed;
            pr_m[c] = 0; rl_m[c] = 0; lg_m[c] = 0; rp_m[c] = 0;
            was = lvl_m[c];
            if (was) held_m[c]++;
            run_m[c] = (seen != was) ? run_m[c] + 1 : 0;
            if (run_m[c] == STABLE) begin
                run_m[c] = 0;
                lvl_m[c] = seen;
                if (seen) begin pr_m[c] = 1; held_m[c] = 0; end
                else rl_m[c] = 1;
            end
            if (was && !rl_m[c]) begin
                if (held_m[c] == LONG) lg_m[c] = 1;
                if (held_m[c] > LONG && ((held_m[c] - LONG) % RPT) == 0) rp_m[c] = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NM; c++) begin
            logic [4:0] obs, exp;
            if (c < CH)
                obs = {level_a[c], press_p_a[c], release_p_a[c], long_p_a[c], repeat_p_a[c]};
            else
                obs = {level_b[c-CH], press_p_b[c-CH], release_p_b[c-CH], long_p_b[c-CH], repeat_p_b[c-CH]};
            exp = {lvl_m[c], pr_m[c], rl_m[c], lg_m[c], rp_m[c]};
            chk($sformatf("model_ch%0d{lvl,pr,rl,lg,rp}", c), 32'(obs), 32'(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        cyc++;
        #1;
        compare_all();
    endtask

    int long_cyc, rpt_cnt, rel_cnt, long_cnt, press_cnt, wait_n;
    int rpt_cyc [3];

    initial begin
        model_reset();
        tick();
        tick();
        chk("reset_outputs_a", 32'({level_a, press_p_a, release_p_a, long_p_a, repeat_p_a}), 32'd0);
        chk("reset_outputs_b", 32'({level_b, press_p_b, release_p_b, long_p_b, repeat_p_b}), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // 1: first sampling edge 10 -> level/press after edge 15, channel 1 untouched
        repeat (9) tick();
        btn_a[0] = 1'b1;
        repeat (5) tick();
        chk("t1_level_before_15", 32'(level_a), 32'd0);
        tick();
        chk("t1_level_at_15", 32'(level_a), 32'b01);
        chk("t1_press_at_15", 32'(press_p_a), 32'b01);

        // 3: hold 40 cycles -> long at +16, repeats at +24, +32, +40
        long_cyc = -1; rpt_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (long_p_a[0]) long_cyc = cyc;
            if (repeat_p_a[0]) begin
                if (rpt_cnt < 3) rpt_cyc[rpt_cnt] = cyc;
                rpt_cnt++;
            end
        end
        chk("t3_long_cycle", 32'(long_cyc), 32'd31);
        chk("t3_repeat1_cycle", 32'(rpt_cyc[0]), 32'd39);
        chk("t3_repeat2_cycle", 32'(rpt_cyc[1]), 32'd47);
        chk("t3_repeat_count", 32'(rpt_cnt), 32'd3);

        btn_a[0] = 1'b0;
        rel_cnt = 0;
        repeat (8) begin tick(); if (release_p_a[0]) rel_cnt++; end
        chk("t3_release_count", 32'(rel_cnt), 32'd1);

        // 2: glitch train 3 high / 1 low never survives the filter
        press_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            btn_a[0] = 1'b1;
            repeat (3) begin tick(); if (press_p_a[0] || level_a[0]) press_cnt++; end
            btn_a[0] = 1'b0;
            tick(); if (press_p_a[0] || level_a[0]) press_cnt++;
        end
        repeat (4) begin tick(); if (press_p_a[0] || level_a[0]) press_cnt++; end
        chk("t2_glitch_no_press", 32'(press_cnt), 32'd0);

        // 4: short press of 10 cycles -> one release, no long
        btn_a[0] = 1'b1;
        repeat (6) tick();
        chk("t4_press", 32'(press_p_a[0]), 32'd1);
        repeat (4) tick();
        btn_a[0] = 1'b0;
        rel_cnt = 0; long_cnt = 0; wait_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (release_p_a[0]) begin rel_cnt++; wait_n = i + 1; end
            if (long_p_a[0]) long_cnt++;
        end
        chk("t4_release_count", 32'(rel_cnt), 32'd1);
        chk("t4_release_latency", 32'(wait_n), 32'd6);
        chk("t4_no_long", 32'(long_cnt), 32'd0);

        // 5: async reset mid-hold, then fresh press and long from zero
        btn_a[0] = 1'b1;
        repeat (6) tick();
        repeat (12) tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_async_reset", 32'({level_a, press_p_a, release_p_a, long_p_a, repeat_p_a}), 32'd0);
        compare_all();
        tick();
        tick();
        rst = 1'b0;
        wait_n = -1; rel_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (press_p_a[0] && wait_n < 0) wait_n = i + 1;
            if (release_p_a[0]) rel_cnt++;
        end
        chk("t5_press_latency", 32'(wait_n), 32'(STABLE + 2));
        chk("t5_no_release", 32'(rel_cnt), 32'd0);
        long_cnt = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (long_p_a[0] && long_cnt < 0) long_cnt = cyc;
        end
        // press was at edge (cyc - 20 - 10 + 6); long is 16 edges later
        chk("t5_long_from_zero", 32'(long_cnt), 32'(cyc - 30 + STABLE + 2 + LONG));
        btn_a[0] = 1'b0;
        repeat (8) tick();

        // 6: active-low instance, both pins pulled low together
        btn_b = 2'b00;
        repeat (5) tick();
        chk("t6_no_press_yet", 32'(press_p_b), 32'd0);
        tick();
        chk("t6_press_both", 32'(press_p_b), 32'b11);
        chk("t6_level_both", 32'(level_b), 32'b11);

        // Random segments on all four channels against the model
        for (int seg = 0; seg < 60; seg++) begin
            btn_a = CH'($urandom);
            btn_b = CH'($urandom);
            wait_n = $urandom_range(1, 30);
            repeat (wait_n) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
